// File: rtl/aud_ctrl_pkg.sv
// Shared types and constants for the audio transport controller.
package aud_ctrl_pkg;
  typedef enum logic [2:0] {
    ST_IDLE, ST_INIT, ST_STOPPED, ST_DSP, ST_WAIT, ST_PAUSED
  } xport_state_e;

  localparam logic MODE_PLAY = 1'b0;
  localparam logic MODE_RECD = 1'b1;

  localparam int SPD_MIN      = 1;
  localparam int SPD_MAX_DEF  = 15;
  localparam int SPD_INIT_DEF = 8;

  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/aud_xport_ctrl_if.sv
// DSP and player/recorder handshake bundle between the controller and the datapath.
interface aud_xport_ctrl_if #(
  parameter int CH    = 2,
  parameter int ADV_W = 4
);
  localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

  logic             dsp_clear;
  logic             dsp_start;
  logic [CHW-1:0]   dsp_ch;
  logic             dsp_fin;
  logic [ADV_W-1:0] dsp_adv;
  logic             io_start;
  logic             io_fin;

  modport master (output dsp_clear, dsp_start, dsp_ch, io_start,
                  input  dsp_fin, dsp_adv, io_fin);
  modport slave  (input  dsp_clear, dsp_start, dsp_ch, io_start,
                  output dsp_fin, dsp_adv, io_fin);
endinterface

// File: rtl/aud_sat_counter.sv
// Up/down counter clamped to [MIN, MAX]; simultaneous inc and dec hold the value.
module aud_sat_counter #(
  parameter int W    = 4,
  parameter int MIN  = 1,
  parameter int MAX  = 15,
  parameter int INIT = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_inc,
  input  logic         i_dec,
  output logic [W-1:0] o_val
);
  localparam logic [W-1:0] VMIN  = W'(MIN);
  localparam logic [W-1:0] VMAX  = W'(MAX);
  localparam logic [W-1:0] VINIT = W'(INIT);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)                                o_val <= VINIT;
    else if (i_inc && !i_dec && o_val != VMAX)   o_val <= o_val + W'(1);
    else if (i_dec && !i_inc && o_val != VMIN)   o_val <= o_val - W'(1);
  end
endmodule

// File: rtl/aud_xport_ctrl.sv
// Audio transport controller: sequences per-channel DSP/IO handshakes per frame,
// owns the frame address and recorded length, and handles stop/pause/loop/speed.
module aud_xport_ctrl
  import aud_ctrl_pkg::*;
#(
  parameter int CH       = 2,
  parameter int ADDR_W   = 20,
  parameter int SPD_W    = 4,
  parameter int SPD_MAX  = SPD_MAX_DEF,
  parameter int SPD_INIT = SPD_INIT_DEF,
  parameter int ADV_W    = 4
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_mode,
  input  logic              i_interpol,
  input  logic              i_loop,
  input  logic              i_key_start,
  input  logic              i_key_stop,
  input  logic              i_key_up,
  input  logic              i_key_down,
  output logic              o_init_start,
  input  logic              i_init_fin,
  aud_xport_ctrl_if.master  bus,
  output logic [ADDR_W-1:0] o_addr,
  output logic [ADDR_W:0]   o_length,
  output logic              o_mode,
  output logic              o_interpol,
  output logic              o_loop,
  output logic [SPD_W-1:0]  o_speed,
  output logic              o_running,
  output logic              o_paused
);
  localparam int CHW = clog2_min1(CH);
  localparam logic [CHW-1:0] LAST_CH = CHW'(CH - 1);

  xport_state_e     state, nxt;
  logic [CHW-1:0]   ch_q, ch_d;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W:0]  len_d, n_addr;
  logic [ADV_W-1:0] adv_q;
  logic             intp_d, loop_d, mode_d;
  logic             dsp_clear_q, dsp_start_q, io_start_q, dsp_start_d, io_start_d;
  logic             stop_p, pause_p, up_p, dn_p;
  logic             stop_any, pause_any, up_any, dn_any;
  logic             spd_inc, spd_dec, frame_end, recd, play_end;

  assign recd      = (o_mode == MODE_RECD);
  assign stop_any  = stop_p  | i_key_stop;
  assign pause_any = pause_p | i_key_start;
  assign up_any    = up_p    | i_key_up;
  assign dn_any    = dn_p    | i_key_down;
  assign n_addr    = {1'b0, o_addr} + (recd ? (ADDR_W+1)'(1) : (ADDR_W+1)'(adv_q));
  assign play_end  = (n_addr >= o_length);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;  ch_d = ch_q;  addr_d = o_addr;  len_d = o_length;
    mode_d = o_mode;  intp_d = o_interpol;  loop_d = o_loop;
    dsp_start_d = 1'b0;  io_start_d = 1'b0;  spd_inc = 1'b0;  spd_dec = 1'b0;
    frame_end = 1'b0;
    unique case (state)
      ST_IDLE: nxt = ST_INIT;
      ST_INIT: if (i_init_fin) nxt = ST_STOPPED;
      ST_STOPPED: begin
        mode_d = i_mode;  intp_d = i_interpol;  loop_d = i_loop;
        spd_inc = i_key_up;  spd_dec = i_key_down;
        if (i_key_start && !i_key_stop && !(i_mode == MODE_PLAY && o_length == '0)) begin
          nxt = ST_DSP;  ch_d = '0;  dsp_start_d = 1'b1;
        end
      end
      ST_DSP: if (bus.dsp_fin) begin
        nxt = ST_WAIT;  io_start_d = 1'b1;
      end
      ST_WAIT: if (bus.io_fin) begin
        if (ch_q != LAST_CH) begin
          nxt = ST_DSP;  ch_d = ch_q + CHW'(1);  dsp_start_d = 1'b1;
        end else begin
          frame_end = 1'b1;
          spd_inc = up_any;  spd_dec = dn_any;
          intp_d = i_interpol;  loop_d = i_loop;
          if (stop_any || (recd && n_addr[ADDR_W])) begin
            nxt = ST_STOPPED;
            if (recd) len_d = n_addr;
          end else if (!recd && play_end && !o_loop) begin
            nxt = ST_STOPPED;
          end else begin
            // A loop wrap restarts from frame 0 but still honours a pending pause.
            addr_d = (!recd && play_end) ? '0 : n_addr[ADDR_W-1:0];
            if (pause_any) nxt = ST_PAUSED;
            else begin
              nxt = ST_DSP;  ch_d = '0;  dsp_start_d = 1'b1;
            end
          end
        end
      end
      ST_PAUSED: begin
        intp_d = i_interpol;  spd_inc = i_key_up;  spd_dec = i_key_down;
        if (i_key_stop) begin
          nxt = ST_STOPPED;
          if (recd) len_d = {1'b0, o_addr};
        end else if (i_key_start) begin
          nxt = ST_DSP;  ch_d = '0;  dsp_start_d = 1'b1;
        end
      end
      default: nxt = ST_IDLE;
    endcase
    if (nxt == ST_STOPPED) addr_d = '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_init_start <= 1'b0;  dsp_clear_q <= 1'b0;  dsp_start_q <= 1'b0;  io_start_q <= 1'b0;
      ch_q <= '0;  o_addr <= '0;  o_length <= '0;  adv_q <= '0;
      o_mode <= MODE_RECD;  o_interpol <= 1'b0;  o_loop <= 1'b0;
      o_running <= 1'b0;  o_paused <= 1'b0;
      stop_p <= 1'b0;  pause_p <= 1'b0;  up_p <= 1'b0;  dn_p <= 1'b0;
    end else begin
      o_init_start <= (nxt == ST_INIT);
      dsp_clear_q  <= (nxt == ST_STOPPED);
      o_running    <= (nxt == ST_DSP) || (nxt == ST_WAIT);
      o_paused     <= (nxt == ST_PAUSED);
      dsp_start_q  <= dsp_start_d;
      io_start_q   <= io_start_d;
      ch_q <= ch_d;  o_addr <= addr_d;  o_length <= len_d;
      o_mode <= mode_d;  o_interpol <= intp_d;  o_loop <= loop_d;
      if (state == ST_DSP && bus.dsp_fin && !recd && ch_q == LAST_CH) adv_q <= bus.dsp_adv;
      if ((state == ST_DSP || state == ST_WAIT) && !frame_end) begin
        stop_p <= stop_any;  pause_p <= pause_any;  up_p <= up_any;  dn_p <= dn_any;
      end else begin
        stop_p <= 1'b0;  pause_p <= 1'b0;  up_p <= 1'b0;  dn_p <= 1'b0;
      end
    end
  end

  assign bus.dsp_clear = dsp_clear_q;
  assign bus.dsp_start = dsp_start_q;
  assign bus.dsp_ch    = ch_q;
  assign bus.io_start  = io_start_q;

  aud_sat_counter #(.W(SPD_W), .MIN(SPD_MIN), .MAX(SPD_MAX), .INIT(SPD_INIT)) u_speed (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_inc  (spd_inc),
    .i_dec  (spd_dec),
    .o_val  (o_speed)
  );
endmodule

// File: tb/tb_aud_xport_ctrl.sv
// Randomized bench for aud_xport_ctrl: frame-level address/length/speed model.
module tb_aud_xport_ctrl;
  localparam int CH = 2, ADDR_W = 3, SPD_W = 4, SPD_MAX = 15, SPD_INIT = 8, ADV_W = 4;
  localparam int DEPTH = 1 << ADDR_W;

  logic gclk = 1'b0;
  logic grst_n;
  always #5 gclk = ~gclk;

  logic mode, interpol, loop_en, k_start, k_stop, k_up, k_down, init_start, init_fin;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   length;
  logic              mode_q, intp_q, loop_q, running, paused;
  logic [SPD_W-1:0]  speed;

  aud_xport_ctrl_if #(.CH(CH), .ADV_W(ADV_W)) bus ();

  aud_xport_ctrl #(.CH(CH), .ADDR_W(ADDR_W), .SPD_W(SPD_W), .SPD_MAX(SPD_MAX),
                   .SPD_INIT(SPD_INIT), .ADV_W(ADV_W)) dut (
    .i_clk(gclk), .i_rst_n(grst_n), .i_mode(mode), .i_interpol(interpol), .i_loop(loop_en),
    .i_key_start(k_start), .i_key_stop(k_stop), .i_key_up(k_up), .i_key_down(k_down),
    .o_init_start(init_start), .i_init_fin(init_fin), .bus(bus),
    .o_addr(addr), .o_length(length), .o_mode(mode_q), .o_interpol(intp_q), .o_loop(loop_q),
    .o_speed(speed), .o_running(running), .o_paused(paused)
  );

  int errors = 0, checks = 0;
  int m_len = 0, m_spd = SPD_INIT;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp_spd(input int v);
    return (v > SPD_MAX) ? SPD_MAX : (v < 1) ? 1 : v;
  endfunction

  task automatic key(input bit s, input bit t, input bit u, input bit d);
    k_start = s;  k_stop = t;  k_up = u;  k_down = d;
    @(negedge gclk);
    k_start = 0;  k_stop = 0;  k_up = 0;  k_down = 0;
  endtask

  task automatic wait_hi(input bit io, input string tag);
    int n = 0;
    while (!(io ? bus.io_start : bus.dsp_start) && n < 40) begin
      @(negedge gclk);
      n++;
    end
    if (n >= 40) chk(tag, 0, 1);
  endtask

  // code: 0 none, 1 start(pause), 2 stop, 3 up, 5 start+stop
  task automatic inject(input int code);
    if (code == 0) return;
    key(code == 1 || code == 5, code == 2 || code == 5, code == 3, 1'b0);
    if (code == 3) chk("spd_hold_run", speed, m_spd);
  endtask

  task automatic run_frame(input int exp_addr, input int adv, input int inj);
    for (int c = 0; c < CH; c++) begin
      wait_hi(1'b0, "dsp_start_timeout");
      chk("dsp_ch", bus.dsp_ch, c);
      chk("frame_addr", addr, exp_addr);
      if (c == 0) chk("running", running, 1);
      repeat ($urandom_range(0, 3)) @(negedge gclk);
      bus.dsp_fin = 1;
      // only the last channel's advance counts; earlier channels send junk
      bus.dsp_adv = (c == CH - 1) ? ADV_W'(adv) : ADV_W'($urandom_range(0, 15));
      @(negedge gclk);
      bus.dsp_fin = 0;
      wait_hi(1'b1, "io_start_timeout");
      if (c == CH - 1) inject(inj);
      repeat ($urandom_range(0, 3)) @(negedge gclk);
      bus.io_fin = 1;
      @(negedge gclk);
      bus.io_fin = 0;
    end
  endtask

  task automatic chk_stopped(input string tag);
    chk({tag, "_running"}, running, 0);
    chk({tag, "_paused"}, paused, 0);
    chk({tag, "_clear"}, bus.dsp_clear, 1);
    chk({tag, "_addr"}, addr, 0);
    chk({tag, "_len"}, length, m_len);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got 0 expected 1");
    $fatal(1);
  end

  initial begin
    int k, adv, a, n;
    mode = 1;  interpol = 0;  loop_en = 0;  init_fin = 0;
    k_start = 0;  k_stop = 0;  k_up = 0;  k_down = 0;
    bus.dsp_fin = 0;  bus.io_fin = 0;  bus.dsp_adv = '0;
    grst_n = 1;
    #1 grst_n = 0;
    #1;
    chk("rst_init_start", init_start, 0);
    chk("rst_dsp_start", bus.dsp_start, 0);
    chk("rst_io_start", bus.io_start, 0);
    chk("rst_clear", bus.dsp_clear, 0);
    chk("rst_ch", bus.dsp_ch, 0);
    chk("rst_addr", addr, 0);
    chk("rst_len", length, 0);
    chk("rst_mode", mode_q, 1);
    chk("rst_intp", intp_q, 0);
    chk("rst_loop", loop_q, 0);
    chk("rst_speed", speed, SPD_INIT);
    chk("rst_run", running, 0);
    chk("rst_pause", paused, 0);
    @(negedge gclk);
    grst_n = 1;
    @(negedge gclk);
    chk("init_req", init_start, 1);
    repeat (3) @(negedge gclk);
    chk("init_hold", init_start, 1);
    init_fin = 1;
    @(negedge gclk);
    init_fin = 0;
    chk("init_done", init_start, 0);
    chk_stopped("after_init");

    // play with nothing recorded is ignored
    mode = 0;
    @(negedge gclk);
    key(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      chk("len0_no_start", bus.dsp_start, 0);
      chk("len0_running", running, 0);
      @(negedge gclk);
    end

    // speed keys while stopped
    n = $urandom_range(8, 12);
    for (int i = 0; i < n; i++) begin key(0, 0, 1, 0); m_spd = clamp_spd(m_spd + 1); end
    chk("spd_up_sat", speed, m_spd);
    key(0, 0, 1, 1);
    chk("spd_up_dn", speed, m_spd);
    n = $urandom_range(15, 20);
    for (int i = 0; i < n; i++) begin key(0, 0, 0, 1); m_spd = clamp_spd(m_spd - 1); end
    chk("spd_dn_sat", speed, m_spd);
    n = $urandom_range(0, 5);
    for (int i = 0; i < n; i++) begin key(0, 0, 1, 0); m_spd = clamp_spd(m_spd + 1); end
    chk("spd_restore", speed, m_spd);

    // full record until memory end
    mode = 1;
    @(negedge gclk);
    key(1, 0, 0, 0);
    for (a = 0; a < DEPTH; a++) begin
      if (a == 3) mode = 0;
      run_frame(a, $urandom_range(0, 15), 0);
      if (a == 3) begin chk("mode_ignored", mode_q, 1); mode = 1; end
    end
    m_len = DEPTH;
    chk_stopped("rec_full");

    // record, pause, resume, pause, stop in pause
    key(1, 0, 0, 0);
    run_frame(0, 0, 0);
    run_frame(1, 0, 1);
    chk("rec_paused", paused, 1);
    chk("rec_pause_addr", addr, 2);
    chk("rec_pause_run", running, 0);
    key(1, 0, 0, 0);
    run_frame(2, 0, 1);
    chk("rec_paused2", paused, 1);
    chk("rec_pause_addr2", addr, 3);
    key(0, 1, 0, 0);
    m_len = 3;
    chk_stopped("rec_pause_stop");

    // record stopped early by key
    k = $urandom_range(4, 7);
    key(1, 0, 0, 0);
    for (a = 0; a < k; a++) run_frame(a, 0, (a == k - 1) ? 2 : 0);
    m_len = k;
    chk_stopped("rec_early");

    // play to end with a speed-up during the first frame
    mode = 0;
    @(negedge gclk);
    adv = $urandom_range(1, 3);
    key(1, 0, 0, 0);
    a = 0;
    while (a < m_len) begin
      run_frame(a, adv, (a == 0) ? 3 : 0);
      if (a == 0) begin m_spd = clamp_spd(m_spd + 1); chk("spd_frame_end", speed, m_spd); end
      a += adv;
    end
    chk_stopped("play_end");

    // looped play, stopped by stop+start together
    loop_en = 1;
    @(negedge gclk);
    adv = $urandom_range(1, 3);
    key(1, 0, 0, 0);
    a = 0;
    for (int f = 0; f < 10; f++) begin
      run_frame(a, adv, (f == 9) ? 5 : 0);
      a += adv;
      if (a >= m_len) a = 0;
    end
    chk_stopped("loop_stop");

    // play pause / resume / stop in pause
    loop_en = 0;
    @(negedge gclk);
    key(1, 0, 0, 0);
    run_frame(0, 1, 1);
    chk("play_paused", paused, 1);
    chk("play_pause_addr", addr, 1);
    interpol = 1;
    @(negedge gclk);
    chk("pause_intp", intp_q, 1);
    key(0, 0, 0, 1);
    m_spd = clamp_spd(m_spd - 1);
    chk("pause_spd", speed, m_spd);
    key(1, 0, 0, 0);
    run_frame(1, 1, 1);
    chk("play_pause_addr2", addr, 2);
    key(0, 1, 0, 0);
    chk_stopped("play_pause_stop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
